bram_stream_reader: RTL

Read-side engine for the asymmetric block RAM: accepts a (base, length) command, walks the BRAM wide read port with `r_valid`/`r_addr`, absorbs its one-cycle registered read latency, and presents the words as a valid/ready stream with a last flag. It sits between the wide port of the shared buffer and any downstream consumer, and it decouples that consumer's back-pressure from the RAM's fixed read timing.

---
 rtl/bram_pkg.sv | 13 +
 rtl/stream_fifo.sv | 61 ++++++
 rtl/bram_stream_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM read-side stream engine.
package bram_pkg;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes are dropped when full; callers bound occupancy with credits.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    head_vld = (count_q != '0);
    head_dat = mem[rd_ptr];
    count    = count_q;
    do_pop   = head_vld && pop_rdy;
    do_push  = push_vld && ((count_q != CNT_W'(DEPTH)) || do_pop);
  end

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a BRAM read port for a (base, len) command and streams the words out with a last flag.
// Latency: first read 1 cycle after the command handshake, first stream word 3 cycles after.
// Backpressure: reads stall once FIFO occupancy plus in-flight reads reach the FIFO depth.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int READ_WIDTH      = 80,
  parameter int READ_ADDR_WIDTH = 9,
  parameter int LEN_WIDTH       = READ_ADDR_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [READ_ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       mem_r_valid,
  output logic [READ_ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [READ_WIDTH-1:0]      mem_r_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [READ_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int CREDIT_W = RD_FIFO_CNT_W + 1;

  rd_state_e                  state_q;
  rd_state_e                  state_d;
  logic [READ_ADDR_WIDTH-1:0] next_addr_q;
  logic [LEN_WIDTH-1:0]       left_q;
  logic                       r_valid_q;
  logic [READ_ADDR_WIDTH-1:0] r_addr_q;
  logic                       r_last_q;
  logic                       cap_vld_q;
  logic                       cap_last_q;
  logic                       done_q;

  logic                       cmd_hs;
  logic                       cmd_zero;
  logic                       issue_vld;
  logic                       issue_last;
  logic [READ_ADDR_WIDTH-1:0] issue_addr;
  logic [CREDIT_W-1:0]        credit_used;
  logic                       credit_ok;
  logic                       drain_done;

  logic                       fifo_vld;
  logic [READ_WIDTH:0]        fifo_dat;
  logic [RD_FIFO_CNT_W-1:0]   fifo_cnt;
  logic                       fifo_pop;

  always_comb begin
    cmd_ready   = (state_q == RD_IDLE) && !done_q;
    cmd_hs      = cmd_valid && cmd_ready;
    cmd_zero    = (cmd_len == '0);
    fifo_pop    = fifo_vld && out_ready;
    // Reads in the BRAM pipeline and in the capture stage already own a FIFO slot.
    credit_used = CREDIT_W'(fifo_cnt) + CREDIT_W'(r_valid_q) + CREDIT_W'(cap_vld_q);
    credit_ok   = (credit_used < CREDIT_W'(RD_FIFO_DEPTH));
    drain_done  = !r_valid_q && !cap_vld_q &&
                  ((fifo_cnt == '0) || ((fifo_cnt == RD_FIFO_CNT_W'(1)) && fifo_pop));

    state_d    = state_q;
    issue_vld  = 1'b0;
    issue_last = 1'b0;
    issue_addr = next_addr_q;
    case (state_q)
      RD_IDLE: begin
        if (cmd_hs && !cmd_zero) begin
          issue_vld  = 1'b1;
          issue_addr = cmd_base;
          issue_last = (cmd_len == LEN_WIDTH'(1));
          state_d    = RD_RUN;
        end
      end
      RD_RUN: begin
        issue_vld  = (left_q != '0) && credit_ok;
        issue_last = (left_q == LEN_WIDTH'(1));
        if ((left_q == '0) || (issue_vld && issue_last)) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (drain_done) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      next_addr_q <= '0;
      left_q      <= '0;
      r_valid_q   <= 1'b0;
      r_addr_q    <= '0;
      r_last_q    <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= ((state_q == RD_IDLE) && cmd_hs && cmd_zero) ||
                    ((state_q == RD_DRAIN) && drain_done);
      r_valid_q  <= issue_vld;
      cap_vld_q  <= r_valid_q;
      cap_last_q <= r_valid_q && r_last_q;
      if (issue_vld) begin
        r_addr_q    <= issue_addr;
        r_last_q    <= issue_last;
        next_addr_q <= issue_addr + 1'b1;
      end
      if ((state_q == RD_IDLE) && cmd_hs && !cmd_zero) begin
        left_q <= cmd_len - 1'b1;
      end else if (issue_vld) begin
        left_q <= left_q - 1'b1;
      end
    end
  end

  stream_fifo #(
    .WIDTH (READ_WIDTH + 1),
    .DEPTH (RD_FIFO_DEPTH),
    .CNT_W (RD_FIFO_CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push_vld (cap_vld_q),
    .push_dat ({cap_last_q, mem_r_data}),
    .pop_rdy  (out_ready),
    .head_vld (fifo_vld),
    .head_dat (fifo_dat),
    .count    (fifo_cnt)
  );

  always_comb begin
    mem_r_valid = r_valid_q;
    mem_r_addr  = r_addr_q;
    out_valid   = fifo_vld;
    out_data    = fifo_dat[READ_WIDTH-1:0];
    out_last    = fifo_vld && fifo_dat[READ_WIDTH];
    busy        = (state_q != RD_IDLE);
    done        = done_q;
  end

endmodule
